// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared constants for the raster timing generator: default 640x480@60
//   geometry, default picture-window placement for the 256x240 PPU image,
//   a helper that sums the four segments of a line/frame, and the pulse
//   bundle type used by the top level.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE   = 640;
   localparam int DEF_H_FP       = 16;
   localparam int DEF_H_SYNC     = 96;
   localparam int DEF_H_BP       = 48;
   localparam int DEF_V_ACTIVE   = 480;
   localparam int DEF_V_FP       = 10;
   localparam int DEF_V_SYNC     = 2;
   localparam int DEF_V_BP       = 33;
   localparam int DEF_WIN_X0     = 64;
   localparam int DEF_WIN_Y0     = 0;
   localparam int DEF_WIN_W      = 256;
   localparam int DEF_WIN_H      = 240;
   localparam int DEF_SCALE_LOG2 = 1;

   // Total counts per axis: active + front porch + sync + back porch.
   function automatic int axis_total(input int act, input int fp,
                                     input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   typedef struct packed {
      logic line_start;
      logic animate;
      logic screenend;
   } pulse_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   Generic wrapping position counter for one raster axis. The next-count
//   value and its decodes are exported combinationally so the parent can
//   register its outputs on the same edge the counter moves.
//   Ports:
//     clk, i_rst     clock, synchronous active-high reset (forces next = 0)
//     i_en           advance enable
//     o_nxt          value the counter holds after this edge
//     o_wrap         this edge wraps MAX -> 0 (carry into the next axis)
//     o_act_nxt      o_nxt < ACT
//     o_sync_nxt     SYNC_LO <= o_nxt < SYNC_HI
module vga_axis_counter #(
   parameter int W       = 11,
   parameter int MAX     = 799,
   parameter int ACT     = 640,
   parameter int SYNC_LO = 656,
   parameter int SYNC_HI = 752
)(
   input  logic         clk,
   input  logic         i_rst,
   input  logic         i_en,
   output logic [W-1:0] o_nxt,
   output logic         o_wrap,
   output logic         o_act_nxt,
   output logic         o_sync_nxt
);
   localparam int W1 = W + 1;
   localparam logic [W-1:0] L_MAX = W'(MAX);
   localparam logic [W-1:0] L_ONE = W'(1);
   // Window bounds compared one bit wider: SYNC_HI may equal MAX+1 = 2^W.
   localparam logic [W:0]   L_ACT = W1'(ACT);
   localparam logic [W:0]   L_SLO = W1'(SYNC_LO);
   localparam logic [W:0]   L_SHI = W1'(SYNC_HI);

   logic [W-1:0] r_cnt;
   logic [W:0]   w_nxt_x;

   always_comb begin
      o_wrap = 1'b0;
      o_nxt  = r_cnt;
      if (i_rst) begin
         o_nxt = '0;
      end else if (i_en) begin
         if (r_cnt == L_MAX) begin
            o_wrap = 1'b1;
            o_nxt  = '0;
         end else begin
            o_nxt = r_cnt + L_ONE;
         end
      end
   end

   assign w_nxt_x    = {1'b0, o_nxt};
   assign o_act_nxt  = (w_nxt_x < L_ACT);
   assign o_sync_nxt = (w_nxt_x >= L_SLO) && (w_nxt_x < L_SHI);

   always_ff @(posedge clk) begin
      if (i_rst)     r_cnt <= '0;
      else if (i_en) r_cnt <= o_nxt;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised raster timing generator with a scaled picture window.
//   Every output is registered from the next-count decode, so outputs move
//   on the same pixel-strobe edge as the counters and hold between strobes.
//   Ports:
//     clk, i_rst            clock, synchronous active-high reset
//     i_pix_stb             pixel advance enable (one clk wide)
//     horizSync, vertSync   syncs, asserted level HS_POL / VS_POL
//     o_active, o_blanking  visible-area flag and its inverse
//     o_x, o_y              raster coordinates (o_x 0 / o_y clamped outside)
//     o_win_active          inside the scaled picture window
//     o_win_x, o_win_y      window-local source coordinates
//     o_line_start, o_animate, o_screenend  one-clk position pulses
//     o_frame               8-bit frame counter
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter bit HS_POL     = 1'b0,
   parameter bit VS_POL     = 1'b0,
   parameter int WIN_X0     = DEF_WIN_X0,
   parameter int WIN_Y0     = DEF_WIN_Y0,
   parameter int WIN_W      = DEF_WIN_W,
   parameter int WIN_H      = DEF_WIN_H,
   parameter int SCALE_LOG2 = DEF_SCALE_LOG2,
   parameter int X_W        = 11,
   parameter int Y_W        = 10
)(
   input  logic           clk,
   input  logic           i_rst,
   input  logic           i_pix_stb,
   output logic           horizSync,
   output logic           vertSync,
   output logic           o_active,
   output logic           o_blanking,
   output logic [X_W-1:0] o_x,
   output logic [Y_W-1:0] o_y,
   output logic           o_win_active,
   output logic [7:0]     o_win_x,
   output logic [7:0]     o_win_y,
   output logic           o_line_start,
   output logic           o_animate,
   output logic           o_screenend,
   output logic [7:0]     o_frame
);
   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int XW1 = X_W + 1;
   localparam int YW1 = Y_W + 1;
   localparam int WIN_X1 = WIN_X0 + (WIN_W << SCALE_LOG2);
   localparam int WIN_Y1 = WIN_Y0 + (WIN_H << SCALE_LOG2);

   localparam logic [X_W:0]   L_WX0   = XW1'(WIN_X0);
   localparam logic [X_W:0]   L_WX1   = XW1'(WIN_X1);
   localparam logic [Y_W:0]   L_WY0   = YW1'(WIN_Y0);
   localparam logic [Y_W:0]   L_WY1   = YW1'(WIN_Y1);
   localparam logic [X_W-1:0] L_WX0N  = X_W'(WIN_X0);
   localparam logic [Y_W-1:0] L_WY0N  = Y_W'(WIN_Y0);
   localparam logic [X_W-1:0] L_HACT  = X_W'(H_ACTIVE);
   localparam logic [X_W-1:0] L_HLAST = X_W'(H_TOTAL - 1);
   localparam logic [Y_W-1:0] L_VALST = Y_W'(V_ACTIVE - 1);
   localparam logic [Y_W-1:0] L_VLAST = Y_W'(V_TOTAL - 1);

   if ((WIN_X1 > H_ACTIVE) || (WIN_Y1 > V_ACTIVE) ||
       ((H_TOTAL - 1) >= (1 << X_W)) || ((V_TOTAL - 1) >= (1 << Y_W)) ||
       (X_W < 8) || (Y_W < 8)) begin : g_cfg_err
      $error("vga_timing_gen: window outside active area or counter too narrow");
   end

   logic [X_W-1:0] w_h_nxt;
   logic [Y_W-1:0] w_v_nxt;
   logic           w_h_wrap, w_v_wrap;
   logic           w_h_act, w_v_act, w_h_sync, w_v_sync;

   vga_axis_counter #(
      .W(X_W), .MAX(H_TOTAL - 1), .ACT(H_ACTIVE),
      .SYNC_LO(H_ACTIVE + H_FP), .SYNC_HI(H_ACTIVE + H_FP + H_SYNC)
   ) u_h (
      .clk(clk), .i_rst(i_rst), .i_en(i_pix_stb),
      .o_nxt(w_h_nxt), .o_wrap(w_h_wrap),
      .o_act_nxt(w_h_act), .o_sync_nxt(w_h_sync)
   );

   // The line carry already includes the strobe and excludes reset.
   vga_axis_counter #(
      .W(Y_W), .MAX(V_TOTAL - 1), .ACT(V_ACTIVE),
      .SYNC_LO(V_ACTIVE + V_FP), .SYNC_HI(V_ACTIVE + V_FP + V_SYNC)
   ) u_v (
      .clk(clk), .i_rst(i_rst), .i_en(w_h_wrap),
      .o_nxt(w_v_nxt), .o_wrap(w_v_wrap),
      .o_act_nxt(w_v_act), .o_sync_nxt(w_v_sync)
   );

   // Window decode on the next position; offsets are taken at full counter
   // width, then scaled down and truncated to the 8-bit source coordinate.
   logic [X_W:0]   w_hx;
   logic [Y_W:0]   w_vx;
   logic [X_W-1:0] w_dx, w_dx_sh;
   logic [Y_W-1:0] w_dy, w_dy_sh;
   logic           w_act, w_win;
   pulse_t         w_pulse;

   assign w_hx    = {1'b0, w_h_nxt};
   assign w_vx    = {1'b0, w_v_nxt};
   assign w_dx    = w_h_nxt - L_WX0N;
   assign w_dy    = w_v_nxt - L_WY0N;
   assign w_dx_sh = w_dx >> SCALE_LOG2;
   assign w_dy_sh = w_dy >> SCALE_LOG2;
   assign w_act   = w_h_act && w_v_act;
   assign w_win   = w_act && (w_hx >= L_WX0) && (w_hx < L_WX1) &&
                    (w_vx >= L_WY0) && (w_vx < L_WY1);

   // A strobe always moves h, so "next equals X" means "entered X".
   always_comb begin
      w_pulse            = '0;
      w_pulse.line_start = w_h_wrap;
      if (i_pix_stb && !i_rst) begin
         w_pulse.animate   = (w_h_nxt == L_HACT)  && (w_v_nxt == L_VALST);
         w_pulse.screenend = (w_h_nxt == L_HLAST) && (w_v_nxt == L_VLAST);
      end
   end

   logic           r_hs, r_vs, r_active, r_win;
   logic [X_W-1:0] r_x;
   logic [Y_W-1:0] r_y;
   logic [7:0]     r_wx, r_wy, r_frame;
   pulse_t         r_pulse;

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_hs     <= ~HS_POL;
         r_vs     <= ~VS_POL;
         r_active <= 1'b1;
         r_x      <= '0;
         r_y      <= '0;
         r_win    <= (WIN_X0 == 0) && (WIN_Y0 == 0);
         r_wx     <= '0;
         r_wy     <= '0;
         r_frame  <= '0;
         r_pulse  <= '0;
      end else begin
         if (i_pix_stb) begin
            r_hs     <= w_h_sync ? HS_POL : ~HS_POL;
            r_vs     <= w_v_sync ? VS_POL : ~VS_POL;
            r_active <= w_act;
            r_x      <= w_act ? w_h_nxt : '0;
            r_y      <= w_v_act ? w_v_nxt : L_VALST;
            r_win    <= w_win;
            r_wx     <= w_win ? w_dx_sh[7:0] : 8'd0;
            r_wy     <= w_win ? w_dy_sh[7:0] : 8'd0;
         end
         if (w_v_wrap) r_frame <= r_frame + 8'd1;
         // Pulses follow the strobe directly so they last exactly one clk.
         r_pulse <= w_pulse;
      end
   end

   assign horizSync    = r_hs;
   assign vertSync     = r_vs;
   assign o_active     = r_active;
   assign o_blanking   = ~r_active;
   assign o_x          = r_x;
   assign o_y          = r_y;
   assign o_win_active = r_win;
   assign o_win_x      = r_wx;
   assign o_win_y      = r_wy;
   assign o_line_start = r_pulse.line_start;
   assign o_animate    = r_pulse.animate;
   assign o_screenend  = r_pulse.screenend;
   assign o_frame      = r_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a small-geometry
// instance with inverted sync polarity share one stimulus stream. A
// position-level reference model (h, v, frame as plain integers) predicts
// every output of both instances each clock; a constant table pins the
// default-geometry line decode, and hand sequences cover whole frames and
// a mid-frame reset.
module tb_vga_timing_gen;

   typedef struct {
      int ha, hfp, hs, hbp, va, vfp, vs, vbp;
      bit hpol, vpol;
      int wx0, wy0, ww, wh, sc;
   } cfg_t;

   typedef struct packed {
      logic hs, vs, act, blank;
      logic [10:0] x;
      logic [9:0]  y;
      logic wa;
      logic [7:0] wx, wy;
      logic ls, an, se;
      logic [7:0] fr;
   } obs_t;

   typedef struct {
      int h, v;
      bit hs, act, wa;
      int wx, wy, x, y;
   } vec_t;

   logic clk, rst, stb;
   logic hs_a, vs_a, act_a, blk_a, wa_a, ls_a, an_a, se_a;
   logic hs_b, vs_b, act_b, blk_b, wa_b, ls_b, an_b, se_b;
   logic [10:0] x_a, x_b;
   logic [9:0]  y_a, y_b;
   logic [7:0]  wx_a, wy_a, fr_a, wx_b, wy_b, fr_b;

   vga_timing_gen u_a (
      .clk(clk), .i_rst(rst), .i_pix_stb(stb),
      .horizSync(hs_a), .vertSync(vs_a), .o_active(act_a), .o_blanking(blk_a),
      .o_x(x_a), .o_y(y_a), .o_win_active(wa_a), .o_win_x(wx_a), .o_win_y(wy_a),
      .o_line_start(ls_a), .o_animate(an_a), .o_screenend(se_a), .o_frame(fr_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .HS_POL(1'b1), .VS_POL(1'b1),
      .WIN_X0(2), .WIN_Y0(1), .WIN_W(6), .WIN_H(5), .SCALE_LOG2(1),
      .X_W(11), .Y_W(10)
   ) u_b (
      .clk(clk), .i_rst(rst), .i_pix_stb(stb),
      .horizSync(hs_b), .vertSync(vs_b), .o_active(act_b), .o_blanking(blk_b),
      .o_x(x_b), .o_y(y_b), .o_win_active(wa_b), .o_win_x(wx_b), .o_win_y(wy_b),
      .o_line_start(ls_b), .o_animate(an_b), .o_screenend(se_b), .o_frame(fr_b)
   );

   obs_t obs_a, obs_b;
   assign obs_a = {hs_a, vs_a, act_a, blk_a, x_a, y_a, wa_a, wx_a, wy_a, ls_a, an_a, se_a, fr_a};
   assign obs_b = {hs_b, vs_b, act_b, blk_b, x_b, y_b, wa_b, wx_b, wy_b, ls_b, an_b, se_b, fr_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int checks = 0;
   int errors = 0;
   cfg_t cfg[2];
   int mh[2], mv[2], mf[2];
   bit mls[2], man[2], mse[2];

   // Expected outputs for a raster position, straight from the timing rules.
   function automatic obs_t model_out(input cfg_t c, input int h, input int v,
                                      input int f, input bit ls, input bit an, input bit se);
      obs_t o;
      bit act, hsa, vsa, inx, iny;
      act = (h < c.ha) && (v < c.va);
      hsa = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs);
      vsa = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs);
      inx = (h >= c.wx0) && (h < c.wx0 + (c.ww << c.sc));
      iny = (v >= c.wy0) && (v < c.wy0 + (c.wh << c.sc));
      o.hs    = hsa ? c.hpol : !c.hpol;
      o.vs    = vsa ? c.vpol : !c.vpol;
      o.act   = act;
      o.blank = !act;
      o.x     = act ? 11'(h) : 11'd0;
      o.y     = (v < c.va) ? 10'(v) : 10'(c.va - 1);
      o.wa    = act && inx && iny;
      o.wx    = o.wa ? 8'((h - c.wx0) >> c.sc) : 8'd0;
      o.wy    = o.wa ? 8'((v - c.wy0) >> c.sc) : 8'd0;
      o.ls    = ls;
      o.an    = an;
      o.se    = se;
      o.fr    = 8'(f);
      return o;
   endfunction

   task automatic chk_obs(input string name, input obs_t got, input obs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, compare #1 later.
   task automatic step(input bit r, input bit s);
      int ht, vt;
      rst = r;
      stb = s;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         ht = cfg[i].ha + cfg[i].hfp + cfg[i].hs + cfg[i].hbp;
         vt = cfg[i].va + cfg[i].vfp + cfg[i].vs + cfg[i].vbp;
         mls[i] = 0; man[i] = 0; mse[i] = 0;
         if (r) begin
            mh[i] = 0; mv[i] = 0; mf[i] = 0;
         end else if (s) begin
            mh[i]++;
            if (mh[i] == ht) begin
               mh[i] = 0;
               mv[i]++;
               if (mv[i] == vt) begin
                  mv[i] = 0;
                  mf[i] = (mf[i] + 1) % 256;
               end
            end
            mls[i] = (mh[i] == 0);
            man[i] = (mh[i] == cfg[i].ha) && (mv[i] == cfg[i].va - 1);
            mse[i] = (mh[i] == ht - 1) && (mv[i] == vt - 1);
         end
      end
      #1;
      chk_obs("model_a", obs_a, model_out(cfg[0], mh[0], mv[0], mf[0], mls[0], man[0], mse[0]));
      chk_obs("model_b", obs_b, model_out(cfg[1], mh[1], mv[1], mf[1], mls[1], man[1], mse[1]));
   endtask

   initial begin
      vec_t tbl[$];
      logic [39:0] got, exp;
      int n, cnt_hs, cnt_ls, cnt_se, cnt_an, cnt_vs;

      cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 64, 0, 256, 240, 1};
      cfg[1] = '{16, 2, 3, 3, 12, 1, 2, 2, 1'b1, 1'b1, 2, 1, 6, 5, 1};

      //            h    v  hs act wa  wx  wy   x    y
      tbl.push_back('{  0, 0, 1, 1, 0,   0, 0,   0, 0});
      tbl.push_back('{ 63, 0, 1, 1, 0,   0, 0,  63, 0});
      tbl.push_back('{ 64, 0, 1, 1, 1,   0, 0,  64, 0});
      tbl.push_back('{ 65, 0, 1, 1, 1,   0, 0,  65, 0});
      tbl.push_back('{ 66, 0, 1, 1, 1,   1, 0,  66, 0});
      tbl.push_back('{575, 0, 1, 1, 1, 255, 0, 575, 0});
      tbl.push_back('{576, 0, 1, 1, 0,   0, 0, 576, 0});
      tbl.push_back('{639, 0, 1, 1, 0,   0, 0, 639, 0});
      tbl.push_back('{640, 0, 1, 0, 0,   0, 0,   0, 0});
      tbl.push_back('{655, 0, 1, 0, 0,   0, 0,   0, 0});
      tbl.push_back('{656, 0, 0, 0, 0,   0, 0,   0, 0});
      tbl.push_back('{751, 0, 0, 0, 0,   0, 0,   0, 0});
      tbl.push_back('{752, 0, 1, 0, 0,   0, 0,   0, 0});
      tbl.push_back('{799, 0, 1, 0, 0,   0, 0,   0, 0});
      tbl.push_back('{  0, 1, 1, 1, 0,   0, 0,   0, 1});
      tbl.push_back('{ 66, 1, 1, 1, 1,   1, 0,  66, 1});
      tbl.push_back('{575, 1, 1, 1, 1, 255, 0, 575, 1});

      rst = 1'b1;
      stb = 1'b0;
      step(1, 0);
      step(1, 1);

      // Default-geometry line decode against hand-computed constants.
      foreach (tbl[k]) begin
         n = 0;
         while (!(mh[0] == tbl[k].h && mv[0] == tbl[k].v) && n < 2000) begin
            step(0, 1);
            n++;
         end
         if (n == 2000) chk_int($sformatf("tbl_reach[%0d]", k), n, -1);
         got = {obs_a.hs, obs_a.act, obs_a.wa, obs_a.wx, obs_a.wy, obs_a.x, obs_a.y};
         exp = {tbl[k].hs, tbl[k].act, tbl[k].wa, 8'(tbl[k].wx), 8'(tbl[k].wy),
                11'(tbl[k].x), 10'(tbl[k].y)};
         chk_obs($sformatf("tbl[%0d]", k), obs_t'({13'd0, got}), obs_t'({13'd0, exp}));
      end

      // One full default line: 96 hsync-low strobes, a single line_start.
      cnt_hs = 0; cnt_ls = 0;
      for (int i = 0; i < 800; i++) begin
         step(0, 1);
         if (!obs_a.hs) cnt_hs++;
         if (obs_a.ls) cnt_ls++;
      end
      chk_int("hs_low_per_line", cnt_hs, 96);
      chk_int("line_start_per_line", cnt_ls, 1);

      // Small geometry: three whole frames from reset.
      step(1, 0);
      cnt_se = 0; cnt_an = 0; cnt_vs = 0;
      for (int i = 0; i < 3 * 408; i++) begin
         step(0, 1);
         if (obs_b.se) cnt_se++;
         if (obs_b.an) cnt_an++;
         if (obs_b.vs) cnt_vs++;
      end
      chk_int("screenend_per_3_frames", cnt_se, 3);
      chk_int("animate_per_3_frames", cnt_an, 3);
      chk_int("vsync_strobes_3_frames", cnt_vs, 144);
      chk_int("frame_after_3", int'(obs_b.fr), 3);

      // Mid-frame reset at (10,6): no screenend, frame cleared, and the next
      // screenend arrives a full frame (407 strobes) after restart.
      n = 0;
      while (!(mh[1] == 10 && mv[1] == 6) && n < 1000) begin
         step(0, 1);
         n++;
      end
      if (n == 1000) chk_int("reset_pos_reach", n, -1);
      step(1, 1);
      chk_int("reset_frame", int'(obs_b.fr), 0);
      chk_int("reset_no_screenend", int'(obs_b.se), 0);
      n = 0;
      do begin
         step(0, 1);
         n++;
      end while (!obs_b.se && n < 1000);
      chk_int("restart_to_screenend", n, 407);

      // Strobe every 4th clk: levels hold, pulses one clk wide.
      for (int i = 0; i < 1700; i++) step(0, (i % 4) == 0);

      // Random strobe with occasional reset.
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 499) == 0, 1'($urandom_range(0, 1)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; successor to the fixed 640x480 sync generator.
- Produces H/V sync with configurable polarity, active/blanking flags and raster coordinates.
- Adds a scaled picture window, so the 256x240 PPU image maps into the display raster with window-local coordinates and window-enable.
- Sits between the pixel-strobe divider and the framebuffer/PPU line-buffer read logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, asserted level of horizSync (0 = active-low)
- VS_POL, 0, asserted level of vertSync
- WIN_X0, 64, first raster column of the window
- WIN_Y0, 0, first raster line of the window
- WIN_W, 256, window width in source pixels
- WIN_H, 240, window height in source lines
- SCALE_LOG2, 1, window scale factor = 2^SCALE_LOG2 in both axes
- X_W, 11, width of raster x and h counter
- Y_W, 10, width of raster y and v counter

Ports:
- clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_pix_stb  in  1  pixel-advance enable, one clk wide
- horizSync  out  1  horizontal sync, level per HS_POL
- vertSync  out  1  vertical sync, level per VS_POL
- o_active  out  1  h<H_ACTIVE and v<V_ACTIVE
- o_blanking  out  1  inverse of o_active
- o_x  out  X_W  raster column h when active, else 0
- o_y  out  Y_W  raster line v when v<V_ACTIVE, else V_ACTIVE-1
- o_win_active  out  1  o_active and (h,v) inside the scaled window
- o_win_x  out  8  (h-WIN_X0)>>SCALE_LOG2 when o_win_active, else 0
- o_win_y  out  8  (v-WIN_Y0)>>SCALE_LOG2 when o_win_active, else 0
- o_line_start  out  1  one-clk pulse: h entered 0
- o_animate  out  1  one-clk pulse: entered (h=H_ACTIVE, v=V_ACTIVE-1), last visible pixel done
- o_screenend  out  1  one-clk pulse: entered (h=H_TOTAL-1, v=V_TOTAL-1)
- o_frame  out  8  frame counter, wraps 255->0

Behaviour:
- Derived: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Line order is active, FP, sync, BP.
- Hsync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). Vsync follows the same rule on v.
- Counters h and v advance only on clk edges with i_pix_stb=1.
- h wraps H_TOTAL-1 -> 0 and increments v.
- v wraps V_TOTAL-1 -> 0 and increments o_frame. Simultaneous h and v wrap is the frame boundary.
- All outputs are registered and decoded from the next-count value. Outputs change on the same edge as the counters (zero latency relative to the counter state) and hold when i_pix_stb=0.
- Pulses (o_line_start, o_animate, o_screenend) are high for exactly one clk after the strobe edge that enters the position. They clear on the next clk even if i_pix_stb stays low.
- Window bounds: WIN_X0 <= h < WIN_X0+(WIN_W<<SCALE_LOG2), and WIN_Y0 <= v < WIN_Y0+(WIN_H<<SCALE_LOG2). Subtraction is done at X_W/Y_W width before the shift, then truncated to 8 bits.
- Reset takes priority over i_pix_stb. On the next edge: h=0, v=0, o_frame=0, o_active=1, o_blanking=0, syncs deasserted (~HS_POL, ~VS_POL), o_x=0, o_y=0, all pulses 0.
- o_win_active after reset is 1 iff WIN_X0=0 and WIN_Y0=0 (0 at defaults); o_win_x=0 and o_win_y=0.
- Reset mid-frame truncates the frame and does not emit o_screenend.
- Elaboration check: the window must fit inside the active area, and X_W/Y_W must hold H_TOTAL-1 and V_TOTAL-1.

Decomposition:
- Package vga_timing_pkg holds the default 640x480@60 constants and an H_TOTAL/V_TOTAL helper function.
- One sub-module, vga_axis_counter, is instantiated twice (horizontal, vertical). It is a generic counter with enable, wrap value, sync-window and active-window decode, and a wrap-carry output.

Test Plan:
- Defaults, i_pix_stb every clk, reset then run 1 line -> horizSync low for exactly h=656..751 (96 strobes); o_line_start pulses once per 800 strobes.
- Full frame -> vertSync low for lines 490..491; o_animate at the h=640,v=479 entry; o_screenend at h=799,v=524; o_frame 0->1 when v wraps 524->0.
- i_pix_stb every 4th clk -> counters and levels hold between strobes; each pulse is 1 clk wide.
- Window at defaults -> at v=0, o_win_active rises at h=64 and falls after h=575; o_win_x=0 for h=64,65, 1 for h=66, 255 at h=575; o_win_y=239 at v=479.
- HS_POL=1, VS_POL=1 -> sync polarity inverted, same positions.
- Assert i_rst at h=300,v=200 -> next clk h=0,v=0,o_frame=0; no o_screenend pulse; timing resumes identically to post-power-on.
